// File: rtl/mem_pkg.sv
// mem_pkg: shared defaults, FSM state encoding and block-base mask for cache_backing_mem.
package mem_pkg;
  localparam int DATA_W_DEF = 10;
  localparam int ADDR_W_DEF = 10;
  localparam int OFFSET_W = 2;
  typedef enum logic [1:0] {IDLE, WAIT, RD_BURST, WR_BURST} state_e;
  function automatic logic [31:0] block_mask(input int off_w);
    return 32'hFFFF_FFFF << off_w;
  endfunction
endpackage

// File: rtl/mem_array.sv
// mem_array: single-port synchronous RAM, one read or one write per cycle, registered read data.
module mem_array #(
  parameter int DW = 10,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
    else if (re) rdata_q <= mem[addr];
  assign rdata = rdata_q;
endmodule

// File: rtl/cache_backing_mem.sv
// cache_backing_mem: fixed-latency burst memory serving cache block fills and write-backs.
// Optional MEM_PARITY_EN adds a stored even-parity bit, parity_err output and inj_err input.
module cache_backing_mem import mem_pkg::*; #(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int BLOCK_WORDS = 1 << OFFSET_W,
  parameter int LATENCY     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wvalid,
  output logic              wready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              done
`ifdef MEM_PARITY_EN
  ,
  input  logic              inj_err,
  output logic              parity_err
`endif
);
  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int WAIT_W = LATENCY > 1 ? $clog2(LATENCY) : 1;
`ifdef MEM_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LATENCY > 0 ? LATENCY - 1 : 0);
  localparam logic [OFF_W:0] K_WR_LAST = (OFF_W+1)'(BLOCK_WORDS - 1);
  localparam logic [OFF_W:0] K_BW = (OFF_W+1)'(BLOCK_WORDS);
  localparam logic [OFF_W:0] K_RD_END = (OFF_W+1)'(BLOCK_WORDS + 1);
  localparam logic [OFF_W:0] K_FIRST = (OFF_W+1)'(2);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, mem_addr;
  logic we_q, we_d, mem_we, mem_re;
  logic [OFF_W:0] k_q, k_d;
  logic [WAIT_W-1:0] w_q, w_d;
  logic [MW-1:0] rdata_q, rdata_d, mem_rdata, mem_wdata;
`ifdef MEM_PARITY_EN
  assign mem_wdata = {^wdata ^ inj_err, wdata};
  assign parity_err = rvalid && ^rdata_q;
`else
  assign mem_wdata = wdata;
`endif
  // k_q indexes the issued read; output beat k appears two cycles later (RAM read + output register)
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    we_d = we_q;
    k_d = k_q;
    w_d = w_q;
    done = 1'b0;
    mem_we = 1'b0;
    mem_re = 1'b0;
    rdata_d = mem_rdata;
    mem_addr = base_q | ADDR_W'(k_q[OFF_W-1:0]);
    busy = state_q != IDLE;
    wready = state_q == WR_BURST;
    rvalid = state_q == RD_BURST && k_q >= K_FIRST;
    case (state_q)
      IDLE: if (req) begin
        base_d = addr & ADDR_W'(block_mask(OFF_W));
        we_d = we;
        k_d = '0;
        w_d = '0;
        state_d = LATENCY > 0 ? WAIT : (we ? WR_BURST : RD_BURST);
      end
      WAIT: begin
        w_d = w_q == WAIT_LAST ? '0 : w_q + 1'b1;
        state_d = w_q != WAIT_LAST ? WAIT : (we_q ? WR_BURST : RD_BURST);
      end
      RD_BURST: begin
        mem_re = k_q < K_BW;
        done = k_q == K_RD_END;
        k_d = done ? '0 : k_q + 1'b1;
        state_d = done ? IDLE : RD_BURST;
      end
      WR_BURST: if (wvalid) begin
        mem_we = 1'b1;
        done = k_q == K_WR_LAST;
        k_d = done ? '0 : k_q + 1'b1;
        state_d = done ? IDLE : WR_BURST;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      base_q <= '0;
      we_q <= 1'b0;
      k_q <= '0;
      w_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      we_q <= we_d;
      k_q <= k_d;
      w_q <= w_d;
      rdata_q <= rdata_d;
    end
  assign rdata = rdata_q[DATA_W-1:0];
  mem_array #(.DW(MW), .AW(ADDR_W)) u_mem (
    .clk(clk),
    .we(mem_we && !rst),
    .re(mem_re),
    .addr(mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );
endmodule
